// File: rtl/bcd_countdown_ctrl.sv
// bcd_countdown_ctrl: MM:SS BCD countdown sequencer for the 7-segment display.
// Loads a sanitised target, counts down at 1 Hz from an internal prescaler,
// supports start/pause/resume/cancel, raises a low-time warning and expiry,
// and drives beeper bursts.
// Optional build macro AUTO_RELOAD_EN: on expiry, reload the shadow value and
// keep running instead of going to DONE.
module bcd_countdown_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned BEEP_TICKS = 3,
    parameter bit          WARN_BEEP  = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    input  logic        cancel,
    input  logic [15:0] warn_value,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        running,
    output logic        warn_flag,
    output logic        expired,
    output logic        beep_flag
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    state_e          state_q, state_d;
    logic [15:0]     time_q, time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
    logic            beep_q, beep_d;
    logic            arm_q, arm_d;
    logic            warn_q, warn_d;
    logic            expired_q, expired_d;
`ifdef AUTO_RELOAD_EN
    logic [15:0]     shadow_q, shadow_d;
`endif

    logic presc_run, tick, warn_now, expiry, burst;

    // Clamp out-of-range BCD digits: any digit to 9, seconds tens to 5.
    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        mu = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        st = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        su = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return {mt, mu, st, su};
    endfunction

    // One-second BCD decrement with borrow chain; never called with 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // Prescaler advances while counting, in DONE, or while a beep is sounding;
    // PAUSE freezes it so resume keeps the sub-second phase.
    assign presc_run = (state_q == S_RUN || state_q == S_DONE || beep_q) &&
                       (state_q != S_PAUSE);
    assign tick      = presc_run && (presc_q == PRESC_MAX);
    assign warn_now  = (state_q == S_RUN || state_q == S_PAUSE) &&
                       (time_q != 16'h0000) && (time_q <= warn_value);

    // Next-state: command decode (cancel > load > pause > start), countdown, beeper.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        arm_d      = arm_q;
        warn_d     = warn_now;
        expiry     = 1'b0;
        burst      = 1'b0;
`ifdef AUTO_RELOAD_EN
        shadow_d   = shadow_q;
`endif
        if (presc_run) presc_d = tick ? '0 : presc_q + PW'(1);

        // Warning beep fires once on the rising edge of the warning level.
        if (!cancel && WARN_BEEP && warn_now && !warn_q && arm_q) begin
            burst = 1'b1;
            arm_d = 1'b0;
        end

        if (cancel) begin
            state_d = S_IDLE;
            time_d  = 16'h0000;
        end else if (load) begin
            time_d  = bcd_sanitize(load_value);
`ifdef AUTO_RELOAD_EN
            shadow_d = bcd_sanitize(load_value);
`endif
            arm_d   = 1'b1;
            state_d = S_LOADED;
        end else if (state_q == S_RUN) begin
            // A tick coinciding with pause still decrements; expiry overrides pause.
            if (pause) state_d = S_PAUSE;
            if (tick) begin
                if (time_q == 16'h0001) begin
                    expiry = 1'b1;
`ifdef AUTO_RELOAD_EN
                    time_d = shadow_q;
                    arm_d  = 1'b1;
`else
                    time_d  = 16'h0000;
                    state_d = S_DONE;
`endif
                end else begin
                    time_d = bcd_dec(time_q);
                end
            end
        end else if (!pause && start) begin
            if (state_q == S_LOADED && time_q != 16'h0000) begin
                state_d = S_RUN;
                presc_d = '0;
            end else if (state_q == S_PAUSE) begin
                state_d = S_RUN;
            end
        end

        // Burst restarts the prescaler so its length is whole ticks.
        if (cancel) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else if (burst || expiry) begin
            beep_d     = 1'b1;
            beep_cnt_d = '0;
            presc_d    = '0;
        end else if (beep_q && tick) begin
            if (beep_cnt_q == BEEP_LAST) begin
                beep_d     = 1'b0;
                beep_cnt_d = '0;
            end else begin
                beep_cnt_d = beep_cnt_q + BW'(1);
            end
        end
        expired_d = expiry;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            time_q     <= 16'h0000;
            presc_q    <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
            arm_q      <= 1'b1;
            warn_q     <= 1'b0;
            expired_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
            shadow_q   <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
            arm_q      <= arm_d;
            warn_q     <= warn_d;
            expired_q  <= expired_d;
`ifdef AUTO_RELOAD_EN
            shadow_q   <= shadow_d;
`endif
        end
    end

    assign time_bcd  = time_q;
    assign state     = state_q;
    assign running   = (state_q == S_RUN);
    assign warn_flag = warn_q;
    assign expired   = expired_q;
    assign beep_flag = beep_q;

endmodule
